// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the microprocessor ROM blocks: FSM encodings,
// default geometry and the compiled-in program image.
package rom_arbiter_pkg;

  localparam int DEF_AW = 6;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Contents of the "prog.list" program image; unlisted words read as zero.
  function automatic logic [31:0] prog_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    case (a)
      32'd5:   w = 32'hA5;
      32'd9:   w = 32'h3C;
      32'd63:  w = 32'h7E;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rom_arbiter_genrom.sv
// Single-port ROM with a one-cycle synchronous read; the image named by
// ROMFILE is compiled in from the package.
module genrom
  import rom_arbiter_pkg::*;
#(
  parameter string ROMFILE = "prog.list",
  parameter int    AW      = DEF_AW,
  parameter int    DW      = DEF_DW
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);

  // Unknown image names yield an all-zero ROM rather than stale contents.
  localparam bit HAS_IMAGE = (ROMFILE == "prog.list");

  always_ff @(posedge clk) begin
    q <= HAS_IMAGE ? DW'(prog_word(32'(addr))) : '0;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of one shared ROM; each access takes
// three cycles (capture, grant/read, respond).
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter string ROMFILE = "prog.list",
  parameter int    AW      = DEF_AW,
  parameter int    DW      = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          vld0,
  output logic          vld1,
  output logic [DW-1:0] data
);

  arb_state_e    state_r, state_d;
  logic [AW-1:0] addr_r;
  logic          owner_r;
  logic          last_r;
  logic          capture;
  logic          winner;
  logic [DW-1:0] rom_q;

  always_comb begin
    capture = (state_r == IDLE) && (req0 || req1);
    // On a tie the port that did not win last time goes next.
    winner  = (req0 && req1) ? ~last_r : req1;
  end

  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE:    if (capture) state_d = READ;
      READ:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      addr_r  <= '0;
      owner_r <= 1'b0;
    end else begin
      state_r <= state_d;
      if (capture) begin
        addr_r  <= winner ? addr1 : addr0;
        owner_r <= winner;
        last_r  <= winner;
      end
    end
  end

  genrom #(
    .ROMFILE (ROMFILE),
    .AW      (AW),
    .DW      (DW)
  ) u_rom (
    .clk  (clk),
    .addr (addr_r),
    .q    (rom_q)
  );

  // ROM output is registered at the end of READ, so it is valid during RESP.
  always_comb begin
    gnt0 = (state_r == READ) && !owner_r;
    gnt1 = (state_r == READ) &&  owner_r;
    vld0 = (state_r == RESP) && !owner_r;
    vld1 = (state_r == RESP) &&  owner_r;
    data = (vld0 || vld1) ? rom_q : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: expected read results are queued when a
// request is raised and compared when the matching vld pulse appears.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, vld0, vld1;
  logic [DW-1:0] data;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];

  rom_arbiter #(
    .ROMFILE ("prog.list"),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .addr0 (addr0),
    .req1  (req1),
    .addr1 (addr1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .vld0  (vld0),
    .vld1  (vld1),
    .data  (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [DW-1:0] val);
    sb_item_t it;
    it.port = port;
    it.val  = val;
    sb_q.push_back(it);
  endtask

  // Protocol checks and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    sb_item_t it;
    check("excl", {29'd0, gnt0 & gnt1, vld0 & vld1, (gnt0 | gnt1) & (vld0 | vld1)}, 32'd0);
    if (vld0 || vld1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_vld", {30'd0, vld0, vld1}, 32'd0);
      end else begin
        it = sb_q.pop_front();
        check("sb_port", {31'd0, vld1}, {31'd0, it.port});
        check("sb_data", {24'd0, data}, {24'd0, it.val});
      end
    end else begin
      check("data_zero", {24'd0, data}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {19'd0, gnt0, gnt1, vld0, vld1, data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request on port 0.
    req0 = 1'b1; addr0 = 6'd5; push(1'b0, 8'hA5);
    @(negedge clk);
    check("single_gnt", {30'd0, gnt0, gnt1}, 32'b10);
    req0 = 1'b0;
    @(negedge clk);
    check("single_vld", {30'd0, vld0, vld1}, 32'b10);
    @(negedge clk);
    check("single_after", {30'd0, vld0, gnt0}, 32'd0);
    repeat (2) @(negedge clk);

    // Tie immediately after reset: port 0 first.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; addr0 = 6'd5; req1 = 1'b1; addr1 = 6'd9;
    push(1'b0, 8'hA5); push(1'b1, 8'h3C);
    @(negedge clk);
    check("tie_gnt0", {30'd0, gnt0, gnt1}, 32'b10);
    req0 = 1'b0;
    @(negedge clk);
    check("tie_vld0", {30'd0, vld0, vld1}, 32'b10);
    @(negedge clk);
    @(negedge clk);
    check("tie_gnt1", {30'd0, gnt0, gnt1}, 32'b01);
    req1 = 1'b0;
    @(negedge clk);
    check("tie_vld1", {30'd0, vld0, vld1}, 32'b01);
    repeat (2) @(negedge clk);

    // Fairness: both held for 12 cycles, grants alternate 0,1,0,1.
    req0 = 1'b1; addr0 = 6'd5; req1 = 1'b1; addr1 = 6'd9;
    for (int g = 0; g < 4; g++) push(g[0], g[0] ? 8'h3C : 8'hA5);
    for (int i = 1; i <= 12; i++) begin
      logic [1:0] exp_g;
      @(negedge clk);
      exp_g = 2'b00;
      if (i % 3 == 1) exp_g = (((i - 1) / 3) % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("fair_gnt_c%0d", i), {30'd0, gnt0, gnt1}, {30'd0, exp_g});
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during READ aborts the access; held request is served afterwards.
    req1 = 1'b1; addr1 = 6'd9;
    @(negedge clk);
    check("rstread_gnt", {30'd0, gnt0, gnt1}, 32'b01);
    rst = 1'b1;
    @(negedge clk);
    check("rstread_outs", {19'd0, gnt0, gnt1, vld0, vld1, data}, 32'd0);
    check("rstread_state", {30'd0, dut.state_r}, {30'd0, IDLE});
    rst = 1'b0; push(1'b1, 8'h3C);
    @(negedge clk);
    check("rstread_regnt", {30'd0, gnt0, gnt1}, 32'b01);
    req1 = 1'b0;
    @(negedge clk);
    check("rstread_vld", {30'd0, vld0, vld1}, 32'b01);
    repeat (2) @(negedge clk);

    // Top address, then address changed during the grant cycle.
    req1 = 1'b1; addr1 = 6'd63; push(1'b1, 8'h7E);
    @(negedge clk);
    check("bound_gnt", {30'd0, gnt0, gnt1}, 32'b01);
    req1 = 1'b0; addr1 = 6'd5;
    @(negedge clk);
    check("bound_vld", {30'd0, vld0, vld1}, 32'b01);
    repeat (2) @(negedge clk);

    // Idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", i), {19'd0, gnt0, gnt1, vld0, vld1, data}, 32'd0);
    end

    check("sb_drain", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
